// File: rtl/qam_demapper_stream.sv
// qam_demapper_stream: run-time selectable QPSK/16QAM/64QAM Gray hard-decision demapper with show-ahead output FIFO
module qam_demapper_stream #(
  parameter int IN_W       = 8,
  parameter int THRESH     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          symbol_clock,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic signed [IN_W-1:0]        I_in,
  input  logic signed [IN_W-1:0]        Q_in,
  input  logic [1:0]                    mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [5:0]                    data_out,
  output logic [1:0]                    mode_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              sym_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int MW = IN_W + 2;
  localparam logic [MW-1:0] T2   = MW'(2 * THRESH);
  localparam logic [MW-1:0] T4   = MW'(4 * THRESH);
  localparam logic [MW-1:0] T6   = MW'(6 * THRESH);
  localparam logic [MW-1:0] MAXM = MW'((1 << (IN_W - 1)) - 1);

  // Magnitude widened by two bits so 6T never overflows; most negative input saturates
  function automatic logic [MW-1:0] mag(input logic signed [IN_W-1:0] x);
    logic signed [MW-1:0] e;
    e = MW'(x);
    return !x[IN_W-1] ? MW'(e) : (x[IN_W-2:0] == '0) ? MAXM : MW'(-e);
  endfunction

  logic [MW-1:0] mi, mq;
  logic          si, sq, accept, ready_en, s1_valid, push, pop;
  logic [1:0]    eff;
  logic [5:0]    bits;
  logic [7:0]    s1_word, head;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

  assign si = I_in[IN_W-1];
  assign sq = Q_in[IN_W-1];
  assign mi = mag(I_in);
  assign mq = mag(Q_in);
  assign push = s1_valid;
  assign pop = out_valid && out_ready;
  assign in_ready = ready_en && !flush && ((level + LW'(s1_valid)) < LW'(FIFO_DEPTH));
  assign accept = in_valid && in_ready;
  assign head = mem[rd_ptr];
  assign data_out = out_valid ? head[5:0] : '0;
  assign mode_out = out_valid ? head[7:6] : '0;
  assign fifo_level = level;

  // Per-symbol decision; reserved mode 3 decodes as 16QAM, Gray levels 10,11,01,00 outward for 64QAM
  always_comb begin
    eff = (mode == 2'd3) ? 2'd1 : mode;
    bits = (eff == 2'd0) ? {4'b0000, si, sq}
         : (eff == 2'd1) ? {2'b00, si, (mi < T2), sq, (mq < T2)}
         : {si, (mi < T4), ((mi >= T2) && (mi < T6)), sq, (mq < T4), ((mq >= T2) && (mq < T6))};
  end

  // Decision register, accept counter and post-reset ready enable
  always_ff @(posedge symbol_clock or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_word   <= '0;
      sym_count <= '0;
    end else begin
      ready_en <= 1'b1;
      s1_valid <= accept;
      if (accept) begin
        s1_word   <= {eff, bits};
        sym_count <= sym_count + CNT_W'(1);
      end
    end
  end

  // FIFO bookkeeping; out_valid only exposes words written on an earlier edge
  always_ff @(posedge symbol_clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level     <= level + LW'(push) - LW'(pop);
      out_valid <= (level - LW'(pop)) != '0;
    end
  end

  // FIFO storage; contents are only observable through out_valid-gated outputs
  always_ff @(posedge symbol_clock) begin
    if (push) mem[wr_ptr] <= s1_word;
  end
endmodule
